// File: rtl/systolic_pe.sv
// Weight-stationary MAC PE: c_out = sat(b_in + weight * a_in), a_in forwarded.
// Define PE_OVF_STICKY_EN to hold overflow until reset or the next weight load.
module systolic_pe #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stationaryCtrl,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] a_out,
    output logic [W-1:0] c_out,
    output logic         overflow,
    output logic [W-1:0] debug_a_data
);

    localparam int SW = 2 * W + 1;

    localparam logic [SW-1:0] MAX_V = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [SW-1:0] MIN_V = {{(W + 2){1'b1}}, {(W - 1){1'b0}}};

    logic [W-1:0]    weight;
    logic [2*W-1:0]  wt_ext;
    logic [2*W-1:0]  a_ext;
    logic [2*W-1:0]  prod;
    logic [SW-1:0]   sum;
    logic [W-1:0]    c_next;
    logic            ovf_next;

    // Low 2W bits of the product of sign-extended operands equal the signed product.
    assign wt_ext = {{W{weight[W-1]}}, weight};
    assign a_ext  = {{W{a_in[W-1]}}, a_in};
    assign prod   = wt_ext * a_ext;
    assign sum    = {{(W + 1){b_in[W-1]}}, b_in} + {prod[2*W-1], prod};

    always_comb begin
        c_next   = sum[W-1:0];
        ovf_next = 1'b0;
        if (stationaryCtrl) begin
            c_next   = b_in;
            ovf_next = 1'b0;
        end else if ($signed(sum) > $signed(MAX_V)) begin
            c_next   = MAX_V[W-1:0];
            ovf_next = 1'b1;
        end else if ($signed(sum) < $signed(MIN_V)) begin
            c_next   = MIN_V[W-1:0];
            ovf_next = 1'b1;
        end
`ifdef PE_OVF_STICKY_EN
        if (!stationaryCtrl && overflow) begin
            ovf_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            weight   <= '0;
            a_out    <= '0;
            c_out    <= '0;
            overflow <= 1'b0;
        end else begin
            a_out    <= a_in;
            c_out    <= c_next;
            overflow <= ovf_next;
            if (stationaryCtrl) begin
                weight <= a_in;
            end
        end
    end

    assign debug_a_data = weight;

endmodule

// File: tb/tb_systolic_pe.sv
// Directed + random checks of systolic_pe against an integer reference model.
// Define PE_OVF_STICKY_EN here too when building the sticky variant.
module tb_systolic_pe;

    localparam int W  = 8;
    localparam int HI = 2 ** (W - 1) - 1;
    localparam int LO = -(2 ** (W - 1));

    logic         clk = 1'b0;
    logic         rst;
    logic         stationaryCtrl;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] a_out;
    logic [W-1:0] c_out;
    logic         overflow;
    logic [W-1:0] debug_a_data;

    int n_vec = 0;
    int n_err = 0;

    int m_w  = 0;
    int m_a  = 0;
    int m_c  = 0;
    bit m_ov = 1'b0;

    systolic_pe #(.W(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .stationaryCtrl (stationaryCtrl),
        .a_in           (a_in),
        .b_in           (b_in),
        .a_out          (a_out),
        .c_out          (c_out),
        .overflow       (overflow),
        .debug_a_data   (debug_a_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic with clamping to the W-bit signed range.
    task automatic model(input bit r, input bit s, input int a, input int b);
        int sum;
        if (r) begin
            m_w  = 0;
            m_a  = 0;
            m_c  = 0;
            m_ov = 1'b0;
        end else begin
            m_a = a;
            if (s) begin
                m_c  = b;
                m_ov = 1'b0;
                m_w  = a;
            end else begin
                sum = b + m_w * a;
`ifdef PE_OVF_STICKY_EN
                m_ov = m_ov || sum > HI || sum < LO;
`else
                m_ov = sum > HI || sum < LO;
`endif
                m_c = sum > HI ? HI : (sum < LO ? LO : sum);
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        rst            = r;
        stationaryCtrl = s;
        a_in           = a;
        b_in           = b;
        @(posedge clk);
        #1;
        model(r, s, int'($signed(a)), int'($signed(b)));
        chk("a_out", a_out, W'(m_a));
        chk("c_out", c_out, W'(m_c));
        chk("overflow", W'(overflow), W'(m_ov));
        chk("weight", debug_a_data, W'(m_w));
    endtask

    initial begin
        rst            = 1'b1;
        stationaryCtrl = 1'b1;
        a_in           = 8'h55;
        b_in           = 8'h33;

        step(1'b1, 1'b1, 8'h55, 8'h33);
        chk("rst_lit_a", a_out, 8'h00);
        chk("rst_lit_w", debug_a_data, 8'h00);

        step(1'b0, 1'b1, 8'h04, 8'h12);
        chk("load_lit_w", debug_a_data, 8'h04);
        chk("load_lit_c", c_out, 8'h12);

        step(1'b0, 1'b0, 8'h10, 8'h04);
        chk("mac_lit_c", c_out, 8'h44);
        step(1'b0, 1'b0, 8'h02, 8'hFE);
        chk("mac2_lit_c", c_out, 8'h06);

        step(1'b0, 1'b1, 8'h10, 8'h00);
        step(1'b0, 1'b0, 8'h20, 8'h00);
        chk("psat_lit_c", c_out, 8'h7F);
        chk("psat_lit_o", W'(overflow), 8'h01);
        step(1'b0, 1'b0, 8'h01, 8'h00);
        chk("psat_next_c", c_out, 8'h10);
`ifdef PE_OVF_STICKY_EN
        chk("psat_next_o", W'(overflow), 8'h01);
`else
        chk("psat_next_o", W'(overflow), 8'h00);
`endif

        step(1'b0, 1'b1, 8'h80, 8'h00);
        step(1'b0, 1'b0, 8'h7F, 8'h80);
        chk("nsat_lit_c", c_out, 8'h80);
        chk("nsat_lit_o", W'(overflow), 8'h01);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        chk("nsat_next_c", c_out, 8'h00);

        step(1'b0, 1'b1, 8'h04, 8'h12);
        step(1'b0, 1'b0, 8'h10, 8'h04);
        step(1'b1, 1'b0, 8'h10, 8'h04);
        chk("mid_rst_c", c_out, 8'h00);
        chk("mid_rst_w", debug_a_data, 8'h00);
        step(1'b0, 1'b0, 8'h10, 8'h04);
        chk("post_rst_c", c_out, 8'h04);

        step(1'b0, 1'b1, 8'h03, 8'h00);
        step(1'b0, 1'b1, 8'hF9, 8'h00);
        chk("b2b_load_w", debug_a_data, 8'hF9);

        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            bit           rr;
            bit           rs;
            rr = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 6) == 0);
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 4) == 0) ra = ra[0] ? 8'h80 : 8'h7F;
            if ($urandom_range(0, 4) == 0) rb = rb[0] ? 8'h80 : 8'h7F;
            step(rr, rs, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
Weight-stationary multiply-accumulate processing element for a 2D systolic array. The PE holds one signed weight in a stationary register, loaded from the a_in stream. It forwards a_in to its neighbour one cycle later, and produces a saturated partial sum c_out = b_in + weight*a_in. PEs are tiled in a grid: a_out feeds the next PE's a_in, and c_out feeds the next PE's b_in.

Parameters:
W, 8, data width of a_in/b_in/a_out/c_out/debug_a_data; all values are signed two's complement.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
stationaryCtrl  input  1  1 = load a_in into the stationary weight register this cycle
a_in  input  W  activation input; carries the weight value when stationaryCtrl=1
b_in  input  W  incoming partial sum, signed
a_out  output  W  a_in delayed one cycle, to the neighbouring PE
c_out  output  W  registered, saturated partial sum, signed
overflow  output  1  registered; 1 when the c_out value of the same cycle was saturated
debug_a_data  output  W  current contents of the stationary weight register

Behaviour:
- All outputs are registered; there are no combinational input-to-output paths.
- Reset: when rst=1 at a rising edge, the weight register, a_out, c_out and overflow all become 0. Reset has priority over every other input, including stationaryCtrl.
- a_out <= a_in every non-reset cycle, regardless of stationaryCtrl. Latency is 1 cycle.
- Load cycle (stationaryCtrl=1):
  - weight <= a_in; debug_a_data shows the new value from the next cycle.
  - c_out <= b_in (partial-sum passthrough); overflow <= 0.
  - No MAC is performed.
- Compute cycle (stationaryCtrl=0):
  - prod = signed(weight) * signed(a_in), 2W bits.
  - sum = sign-extended b_in + prod, 2W+1 bits.
  - If sum > 2^(W-1)-1: c_out <= 2^(W-1)-1 and overflow <= 1.
  - If sum < -2^(W-1): c_out <= -2^(W-1) and overflow <= 1.
  - Otherwise: c_out <= sum[W-1:0] and overflow <= 0.
- The weight register holds its value indefinitely until the next load cycle or reset.
- Back-to-back loads are legal; the last one wins.
- Pipeline latency from a_in/b_in to c_out/overflow is 1 cycle.
- The datapath must be fully pipelined: a new input is accepted every cycle, with no handshake and no stalls.
- Reset asserted mid-stream discards any in-flight result. The first valid output after reset appears one cycle after rst deasserts.
- No X propagation: all state elements are reset.

Optional Feature:
PE_OVF_STICKY_EN
- Defined: overflow is sticky. Once set by a saturating compute cycle it stays 1 until rst or a load cycle (stationaryCtrl=1) clears it. c_out saturation behaviour is unchanged.
- Undefined: overflow reflects only the current c_out value, as described in Behaviour.

Test Plan:
1. Reset: hold rst=1 for one edge with arbitrary inputs, including stationaryCtrl=1, a_in=0x55 -> a_out=0x00, c_out=0x00, overflow=0, debug_a_data=0x00.
2. Weight load: stationaryCtrl=1, a_in=0x04, b_in=0x12 -> next cycle debug_a_data=0x04, a_out=0x04, c_out=0x12, overflow=0.
3. Normal MAC: with weight=0x04, stationaryCtrl=0, a_in=0x10, b_in=0x04 -> next cycle c_out=0x44 (16*4+4=68), a_out=0x10, overflow=0. Weight holds for further cycles: a_in=0x02, b_in=0xFE -> c_out=0x06.
4. Positive saturation: load weight 0x10, then a_in=0x20, b_in=0x00 -> sum 512 -> c_out=0x7F, overflow=1. The following cycle, a_in=0x01, b_in=0x00 -> c_out=0x10, overflow=0; with PE_OVF_STICKY_EN, overflow stays 1.
5. Negative saturation: load weight 0x80 (-128), then a_in=0x7F, b_in=0x80 -> sum -16384 -> c_out=0x80, overflow=1. Then a_in=0x00, b_in=0x00 -> c_out=0x00.
6. Reset mid-stream: during the compute sequence of scenario 3, assert rst for one edge -> all outputs 0 and debug_a_data=0. The next compute cycle with a_in=0x10, b_in=0x04 gives c_out=0x04 (weight=0).
